sysbus_arbiter: RTL and testbench

- Shares the single Sysbus top-side master port between NCLIENTS requesters (e.g. I-cache fill, D-cache fill/writeback).
- Sits between the core's memory clients and the uncore bus. Exactly one transaction is in flight at a time.
- Grants rotate round-robin. The owner keeps the bus through its request phase and, for reads, through its full response burst.

---
 rtl/sysbus_pkg.sv | 22 ++
 rtl/sysbus_arbiter_rr_pick.sv | 31 +++
 rtl/sysbus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared types and helpers for the Sysbus arbiter
package sysbus_pkg;

  localparam int SYSBUS_TAG_WIDTH = 13;
  localparam int TAG_WRITE_BIT    = SYSBUS_TAG_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width needed to index n items; never less than one bit.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int tag_write_bit(input int tag_width);
    return tag_width - 1;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_pick.sv
// rtl/sysbus_arbiter_rr_pick.sv - round-robin picker: first set request at or after ptr, with wrap
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         valid
);

  logic [N-1:0] rot;
  int           s;

  // Rotate so that ptr lands on bit 0; scanning downward lets the lowest offset win.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    s     = 0;
    rot   = N'({req, req} >> ptr);
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        s     = int'(ptr) + j;
        if (s >= N) s = s - N;
        grant = W'(s);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - shares one Sysbus master port between NCLIENTS requesters
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int NCLIENTS   = 2,
  parameter int RESP_BEATS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCLIENTS*DATA_WIDTH-1:0] creq,
  input  logic [NCLIENTS*TAG_WIDTH-1:0]  creqtag,
  input  logic [NCLIENTS-1:0]            creqcyc,
  output logic [NCLIENTS-1:0]            creqack,
  output logic [NCLIENTS*DATA_WIDTH-1:0] cresp,
  output logic [NCLIENTS*TAG_WIDTH-1:0]  cresptag,
  output logic [NCLIENTS-1:0]            crespcyc,
  input  logic [NCLIENTS-1:0]            crespack,
  output logic [DATA_WIDTH-1:0]          req,
  output logic [TAG_WIDTH-1:0]           reqtag,
  output logic                           reqcyc,
  input  logic                           reqack,
  input  logic [DATA_WIDTH-1:0]          resp,
  input  logic [TAG_WIDTH-1:0]           resptag,
  input  logic                           respcyc,
  output logic                           respack,
  output logic [clog2w(NCLIENTS)-1:0]    owner,
  output logic                           stray
);

  localparam int OW   = clog2w(NCLIENTS);
  localparam int CW   = clog2w(RESP_BEATS);
  localparam int WBIT = tag_write_bit(TAG_WIDTH);

  arb_state_t      state, state_nx;
  logic [OW-1:0]   rr, rr_nx, owner_nx;
  logic [CW-1:0]   beat, beat_nx;
  logic            is_write, is_write_nx;
  logic            acked, acked_nx;

  logic [OW-1:0]   pick;
  logic            pick_valid;

  logic                  own_cyc;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_tag;
  logic                  own_respack;

  rr_pick #(
    .N (NCLIENTS),
    .W (OW)
  ) u_rr_pick (
    .req   (creqcyc),
    .ptr   (rr),
    .grant (pick),
    .valid (pick_valid)
  );

  // Owner's request-side signals, muxed once for both FSM and bus outputs.
  always_comb begin
    own_cyc     = 1'b0;
    own_req     = '0;
    own_tag     = '0;
    own_respack = 1'b0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (owner == OW'(i)) begin
        own_cyc     = creqcyc[i];
        own_req     = creq[i*DATA_WIDTH +: DATA_WIDTH];
        own_tag     = creqtag[i*TAG_WIDTH +: TAG_WIDTH];
        own_respack = crespack[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= '0;
      owner    <= '0;
      beat     <= '0;
      is_write <= 1'b0;
      acked    <= 1'b0;
    end else begin
      state    <= state_nx;
      rr       <= rr_nx;
      owner    <= owner_nx;
      beat     <= beat_nx;
      is_write <= is_write_nx;
      acked    <= acked_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    rr_nx       = rr;
    owner_nx    = owner;
    beat_nx     = beat;
    is_write_nx = is_write;
    acked_nx    = acked;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nx = pick;
          rr_nx    = (pick == OW'(NCLIENTS - 1)) ? '0 : pick + 1'b1;
          acked_nx = 1'b0;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (own_cyc && reqack && !acked) begin
          acked_nx    = 1'b1;
          is_write_nx = own_tag[WBIT];
        end
        // A drop before any ack is a withdrawn request; writes expect no response.
        if (!own_cyc) begin
          if (!acked || is_write) begin
            state_nx = IDLE;
          end else begin
            state_nx = RESP;
            beat_nx  = '0;
          end
        end
      end
      RESP: begin
        if (respcyc && own_respack) begin
          if (beat == CW'(RESP_BEATS - 1)) state_nx = IDLE;
          else                             beat_nx  = beat + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req      = '0;
    reqtag   = '0;
    reqcyc   = 1'b0;
    creqack  = '0;
    cresp    = '0;
    cresptag = '0;
    crespcyc = '0;
    respack  = 1'b0;
    stray    = 1'b0;
    case (state)
      REQ: begin
        req    = own_req;
        reqtag = own_tag;
        reqcyc = own_cyc;
        stray  = respcyc;
        for (int i = 0; i < NCLIENTS; i++) begin
          if (owner == OW'(i)) creqack[i] = reqack;
        end
      end
      RESP: begin
        respack = own_respack;
        for (int i = 0; i < NCLIENTS; i++) begin
          if (owner == OW'(i)) begin
            cresp[i*DATA_WIDTH +: DATA_WIDTH]  = resp;
            cresptag[i*TAG_WIDTH +: TAG_WIDTH] = resptag;
            crespcyc[i]                        = respcyc;
          end
        end
      end
      default: stray = respcyc;
    endcase
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb/tb_sysbus_arbiter.sv - directed vector bench for sysbus_arbiter
module tb_sysbus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NC = 2;

  localparam logic [TW-1:0] RTAG = 13'h0040;
  localparam logic [TW-1:0] WTAG = 13'h1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] creq;
  logic [NC*TW-1:0] creqtag;
  logic [NC-1:0]    creqcyc, creqack, crespcyc, crespack;
  logic [NC*DW-1:0] cresp;
  logic [NC*TW-1:0] cresptag;
  logic [DW-1:0]    req, resp;
  logic [TW-1:0]    reqtag, resptag;
  logic             reqcyc, reqack, respcyc, respack, stray;
  logic [0:0]       owner;

  sysbus_arbiter #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .NCLIENTS   (NC),
    .RESP_BEATS (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .creq     (creq),
    .creqtag  (creqtag),
    .creqcyc  (creqcyc),
    .creqack  (creqack),
    .cresp    (cresp),
    .cresptag (cresptag),
    .crespcyc (crespcyc),
    .crespack (crespack),
    .req      (req),
    .reqtag   (reqtag),
    .reqcyc   (reqcyc),
    .reqack   (reqack),
    .resp     (resp),
    .resptag  (resptag),
    .respcyc  (respcyc),
    .respack  (respack),
    .owner    (owner),
    .stray    (stray)
  );

  typedef struct {
    logic [1:0]  cyc;
    logic        rack;
    logic        rcyc;
    logic [1:0]  cack;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected bundle: {reqcyc, creqack, crespcyc, respack, stray, owner, reqtag}
  task automatic add(input logic [1:0] cyc, input logic rack, input logic rcyc, input logic [1:0] cack,
                     input logic e_rc, input logic [1:0] e_ca, input logic [1:0] e_cc,
                     input logic e_ra, input logic e_st, input logic e_ow, input logic [TW-1:0] e_tag);
    vec_t v;
    v.cyc  = cyc;
    v.rack = rack;
    v.rcyc = rcyc;
    v.cack = cack;
    v.exp  = {e_rc, e_ca, e_cc, e_ra, e_st, e_ow, e_tag};
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; creqcyc = '0; reqack = 1'b0; respcyc = 1'b0; crespack = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    int cnt;
    logic [0:0] e_own;

    reset    = 1'b1;
    creq     = {64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0};
    creqtag  = {WTAG, RTAG};
    creqcyc  = '0;
    crespack = '0;
    reqack   = 1'b0;
    resp     = '0;
    resptag  = 13'h00aa;
    respcyc  = 1'b0;

    // cyc rack rcyc cack | reqcyc creqack crespcyc respack stray owner reqtag
    add(2'b00, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0, 13'h0);
    add(2'b00, 0, 1, 2'b11,  0, 2'b00, 2'b00, 0, 1, 0, 13'h0);
    add(2'b01, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0, 13'h0);
    add(2'b01, 0, 0, 2'b00,  1, 2'b00, 2'b00, 0, 0, 0, RTAG);
    add(2'b11, 1, 0, 2'b00,  1, 2'b01, 2'b00, 0, 0, 0, RTAG);
    add(2'b10, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0, RTAG);
    add(2'b10, 0, 0, 2'b01,  0, 2'b00, 2'b00, 1, 0, 0, 13'h0);
    for (int b = 0; b < 8; b++)
      add(2'b10, 0, 1, 2'b01, 0, 2'b00, 2'b01, 1, 0, 0, 13'h0);
    add(2'b10, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0, 13'h0);
    add(2'b10, 1, 0, 2'b00,  1, 2'b10, 2'b00, 0, 0, 1, WTAG);
    add(2'b00, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 1, WTAG);
    add(2'b00, 0, 1, 2'b00,  0, 2'b00, 2'b00, 0, 1, 1, 13'h0);
    add(2'b01, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 1, 13'h0);
    add(2'b00, 0, 1, 2'b11,  0, 2'b00, 2'b00, 0, 1, 0, RTAG);
    add(2'b00, 0, 1, 2'b00,  0, 2'b00, 2'b00, 0, 1, 0, 13'h0);
    add(2'b00, 0, 0, 2'b00,  0, 2'b00, 2'b00, 0, 0, 0, 13'h0);

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      creqcyc  = vecs[i].cyc;
      reqack   = vecs[i].rack;
      respcyc  = vecs[i].rcyc;
      crespack = vecs[i].cack;
      resp     = 64'(i);
      #2;
      chk($sformatf("vec%0d", i), {reqcyc, creqack, crespcyc, respack, stray, owner, reqtag}, vecs[i].exp);
    end

    // Write burst: client1, eight back-to-back beats, never a response phase.
    @(negedge clk);
    creqtag = {WTAG, RTAG}; creqcyc = 2'b10; reqack = 1'b0; respcyc = 1'b0; crespack = '0;
    #2 chk("wr_idle_reqcyc", reqcyc, 1'b0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      reqack = 1'b1;
      #2 chk($sformatf("wr_beat%0d", b), {creqack, reqcyc, req}, {2'b10, 1'b1, 64'h00B1});
    end
    @(negedge clk);
    creqcyc = 2'b00; reqack = 1'b0;
    #2 chk("wr_drop", {reqcyc, creqack}, 3'b000);
    @(negedge clk);
    respcyc = 1'b1;
    #2 chk("wr_then_idle", {stray, respack, crespcyc}, 4'b1000);

    // Read with response backpressure from client0.
    @(negedge clk);
    respcyc = 1'b0; creqcyc = 2'b01;
    @(negedge clk);
    reqack = 1'b1;
    #2 chk("bp_req", {owner, creqack}, 3'b001);
    @(negedge clk);
    reqack = 1'b0; creqcyc = 2'b00;
    k = 0;
    cnt = 0;
    while (k < 8 && cnt < 40) begin
      @(negedge clk);
      respcyc  = 1'b1;
      resp     = 64'(k);
      crespack = {1'b0, (cnt % 2 == 0)};
      #2;
      chk("bp_respack", respack, crespack[0]);
      chk("bp_crespcyc", {stray, crespcyc}, 3'b001);
      if (crespack[0]) begin
        chk("bp_data", {cresp, cresptag}, {64'h0, 64'(k), 13'h0, 13'h00aa});
        k++;
      end
      cnt++;
    end
    chk("bp_beats", k, 8);
    @(negedge clk);
    crespack = 2'b01;
    #2 chk("bp_back_idle", {stray, respack, crespcyc}, 4'b1000);

    // Reset in the middle of a client1 read response.
    @(negedge clk);
    respcyc = 1'b0; crespack = '0; creqtag = {13'h0041, RTAG}; creqcyc = 2'b10;
    @(negedge clk);
    reqack = 1'b1;
    @(negedge clk);
    reqack = 1'b0; creqcyc = 2'b00;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      respcyc = 1'b1; crespack = 2'b10;
      #2 chk($sformatf("rst_beat%0d", b), {owner, crespcyc, respack}, 4'b1101);
    end
    @(negedge clk);
    reset = 1'b1; respcyc = 1'b0; crespack = '0;
    @(negedge clk);
    reset = 1'b0; respcyc = 1'b1;
    #2 chk("rst_after", {reqcyc, owner, stray, respack, crespcyc}, 6'b001000);
    @(negedge clk);
    respcyc = 1'b0; creqcyc = 2'b10;
    @(negedge clk);
    #2 chk("rst_regrant", {owner, reqcyc, reqtag}, {1'b1, 1'b1, 13'h0041});
    @(negedge clk);
    creqcyc = 2'b00;

    // Contention from reset: both always requesting writes, grants must alternate.
    do_reset();
    creqtag = {WTAG, 13'h1001};
    for (int t = 0; t < 4; t++) begin
      e_own = 1'(t % 2);
      @(negedge clk);
      creqcyc = 2'b11; reqack = 1'b0;
      #2 chk($sformatf("rr_idle%0d", t), reqcyc, 1'b0);
      @(negedge clk);
      reqack = 1'b1;
      #2 chk($sformatf("rr_grant%0d", t), {owner, creqack}, {e_own, (e_own ? 2'b10 : 2'b01)});
      @(negedge clk);
      reqack = 1'b0;
      creqcyc[e_own] = 1'b0;
      #2 chk($sformatf("rr_drop%0d", t), {reqcyc, creqack}, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
